// File: rtl/music_sequencer.sv
// rtl/music_sequencer.sv - song sequencer stepping {note, dur} entries from an external song ROM
module music_sequencer #(
  parameter int NOTE_W   = 20,
  parameter int DUR_W    = 4,
  parameter int SONG_W   = 3,
  parameter int LEN_W    = 6,
  parameter int TICK_DIV = 2500000,
  parameter int CNT_W    = 22
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SONG_W-1:0]         song_sel,
  input  logic                      play,
  input  logic                      stop,
  input  logic                      pause_toggle,
  input  logic                      loop_en,
  output logic [SONG_W+LEN_W-1:0]   rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  output logic [NOTE_W-1:0]         note_div,
  output logic                      playing,
  output logic                      paused,
  output logic                      song_done,
  output logic [LEN_W-1:0]          note_idx
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_PLAY   = 3'd3;
  localparam logic [2:0] S_PAUSED = 3'd4;

  localparam logic [LEN_W-1:0] LAST_IDX = '1;
  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

  logic [2:0]              state, state_n;
  logic [SONG_W-1:0]       cur_song, cur_song_n;
  logic [LEN_W-1:0]        note_idx_n;
  logic [SONG_W+LEN_W-1:0] rom_addr_n;
  logic [NOTE_W-1:0]       note_div_n;
  logic [NOTE_W-1:0]       note_hold, note_hold_n;
  logic [DUR_W-1:0]        dur_cnt, dur_cnt_n;
  logic [CNT_W-1:0]        tick_cnt, tick_cnt_n;
  logic                    song_done_n;
  logic                    end_song;

  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;
  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  always_comb begin
    state_n     = state;
    cur_song_n  = cur_song;
    note_idx_n  = note_idx;
    rom_addr_n  = rom_addr;
    note_div_n  = note_div;
    note_hold_n = note_hold;
    dur_cnt_n   = dur_cnt;
    tick_cnt_n  = tick_cnt;
    song_done_n = 1'b0;
    end_song    = 1'b0;

    if (stop) begin
      state_n    = S_IDLE;
      note_div_n = '0;
    end else if (play || (state != S_IDLE && song_sel != cur_song)) begin
      // rom_addr moves on entry to FETCH so ROM data is ready by LOAD
      state_n    = S_FETCH;
      cur_song_n = song_sel;
      note_idx_n = '0;
      rom_addr_n = {song_sel, {LEN_W{1'b0}}};
    end else if (pause_toggle && state == S_PLAY) begin
      state_n    = S_PAUSED;
      note_div_n = '0;
    end else if (pause_toggle && state == S_PAUSED) begin
      state_n    = S_PLAY;
      note_div_n = note_hold;
    end else begin
      case (state)
        S_FETCH: begin
          rom_addr_n = {cur_song, note_idx};
          state_n    = S_LOAD;
        end
        S_LOAD: begin
          if (rom_dur == '0) begin
            end_song = 1'b1;
          end else begin
            note_div_n  = rom_note;
            note_hold_n = rom_note;
            dur_cnt_n   = rom_dur;
            tick_cnt_n  = '0;
            state_n     = S_PLAY;
          end
        end
        S_PLAY: begin
          if (tick_cnt == TICK_MAX) begin
            tick_cnt_n = '0;
            dur_cnt_n  = dur_cnt - DUR_W'(1);
            if (dur_cnt == DUR_W'(1)) begin
              // the last slot of a song has no room for a marker, so it ends here
              if (note_idx == LAST_IDX) begin
                end_song = 1'b1;
              end else begin
                note_idx_n = note_idx + LEN_W'(1);
                rom_addr_n = {cur_song, note_idx + LEN_W'(1)};
                state_n    = S_FETCH;
              end
            end
          end else begin
            tick_cnt_n = tick_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase

      if (end_song) begin
        if (loop_en) begin
          note_idx_n = '0;
          rom_addr_n = {cur_song, {LEN_W{1'b0}}};
          state_n    = S_FETCH;
        end else begin
          song_done_n = 1'b1;
          note_div_n  = '0;
          state_n     = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_song  <= '0;
      note_idx  <= '0;
      rom_addr  <= '0;
      note_div  <= '0;
      note_hold <= '0;
      dur_cnt   <= '0;
      tick_cnt  <= '0;
      playing   <= 1'b0;
      paused    <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state     <= state_n;
      cur_song  <= cur_song_n;
      note_idx  <= note_idx_n;
      rom_addr  <= rom_addr_n;
      note_div  <= note_div_n;
      note_hold <= note_hold_n;
      dur_cnt   <= dur_cnt_n;
      tick_cnt  <= tick_cnt_n;
      playing   <= (state_n == S_FETCH) || (state_n == S_LOAD) || (state_n == S_PLAY);
      paused    <= (state_n == S_PAUSED);
      song_done <= song_done_n;
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// tb/tb_music_sequencer.sv - scoreboard bench for music_sequencer
module tb_music_sequencer;

  localparam int NOTE_W = 20;
  localparam int DUR_W  = 4;
  localparam int SONG_W = 3;
  localparam int LEN_W  = 6;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [SONG_W-1:0]         song_sel;
  logic                      play, stop, pause_toggle, loop_en;
  logic [SONG_W+LEN_W-1:0]   rom_addr;
  logic [NOTE_W+DUR_W-1:0]   rom_data;
  logic [NOTE_W-1:0]         note_div;
  logic                      playing, paused, song_done;
  logic [LEN_W-1:0]          note_idx;

  logic [NOTE_W+DUR_W-1:0] rom [0:(1<<(SONG_W+LEN_W))-1];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [NOTE_W-1:0] nd;
    logic              done;
    int                gap;
  } ev_t;
  ev_t exp_q[$];

  music_sequencer #(
    .NOTE_W(NOTE_W), .DUR_W(DUR_W), .SONG_W(SONG_W), .LEN_W(LEN_W),
    .TICK_DIV(4), .CNT_W(22)
  ) dut (
    .clk(clk), .rst(rst), .song_sel(song_sel), .play(play), .stop(stop),
    .pause_toggle(pause_toggle), .loop_en(loop_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .note_div(note_div), .playing(playing), .paused(paused),
    .song_done(song_done), .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  // synchronous song ROM: data follows rom_addr by one clock
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_play();
    play = 1'b1;
    tick(1);
    play = 1'b0;
  endtask

  task automatic exp_ev(input logic [NOTE_W-1:0] nd, input logic done, input int gap);
    ev_t e;
    e.nd = nd;
    e.done = done;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // monitor: an output event is any note_div change or a song_done pulse;
  // gap is counted from the previous event or control input
  int cyc = 0;
  int ref_cyc = 0;
  logic [NOTE_W-1:0] prev_nd = '0;
  logic [SONG_W-1:0] prev_sel = '0;
  always @(negedge clk) begin
    ev_t e;
    int gap;
    cyc++;
    if (note_div !== prev_nd || song_done === 1'b1) begin
      gap = cyc - ref_cyc;
      ref_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected actual_nd=%0d actual_done=%0d gap=%0d expected=none",
                 note_div, song_done, gap);
      end else begin
        e = exp_q.pop_front();
        if (note_div !== e.nd || song_done !== e.done || gap != e.gap) begin
          failures++;
          $display("FAIL sb_event actual_nd=%0d done=%0d gap=%0d expected_nd=%0d done=%0d gap=%0d",
                   note_div, song_done, gap, e.nd, e.done, e.gap);
        end
      end
    end
    if (play || stop || pause_toggle || song_sel !== prev_sel) ref_cyc = cyc;
    prev_nd = note_div;
    prev_sel = song_sel;
  end

  initial begin
    for (int i = 0; i < (1 << (SONG_W + LEN_W)); i++) rom[i] = '0;
    rom[{3'd1, 6'd0}] = {20'd100, 4'd2};
    rom[{3'd1, 6'd1}] = {20'd200, 4'd1};
    rom[{3'd2, 6'd0}] = {20'd300, 4'd1};
    for (int i = 0; i < 64; i++) rom[{3'd3, 6'(i)}] = {20'(1000 + i), 4'd1};
    rom[{3'd4, 6'd0}] = {20'd700, 4'd1};

    rst = 1'b1; song_sel = '0; play = 0; stop = 0; pause_toggle = 0; loop_en = 0;
    tick(3);
    chk("rst_note_div", 32'(note_div), 0);
    chk("rst_playing", 32'(playing), 0);
    chk("rst_paused", 32'(paused), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_note_idx", 32'(note_idx), 0);
    rst = 1'b0;
    tick(2);

    // basic song: 100 x 8 cycles, 2-cycle fetch, 200 x 4, then done
    song_sel = 3'd1;
    tick(1);
    exp_ev(20'd100, 1'b0, 3);
    exp_ev(20'd200, 1'b0, 10);
    exp_ev(20'd0, 1'b1, 6);
    pulse_play();
    tick(25);
    chk("done_playing", 32'(playing), 0);
    chk("done_note_div", 32'(note_div), 0);

    // loop mode: end marker jumps back to entry 0, then stop
    loop_en = 1'b1;
    exp_ev(20'd100, 1'b0, 3);
    exp_ev(20'd200, 1'b0, 10);
    exp_ev(20'd100, 1'b0, 8);
    exp_ev(20'd0, 1'b0, 1);
    pulse_play();
    tick(21);
    #4;
    chk("loop_note_idx", 32'(note_idx), 0);
    chk("loop_note_div", 32'(note_div), 100);
    tick(3);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    loop_en = 1'b0;
    tick(5);

    // pause after 3 counted cycles, hold 20, resume for the remaining 5
    exp_ev(20'd100, 1'b0, 3);
    exp_ev(20'd0, 1'b0, 1);
    exp_ev(20'd100, 1'b0, 1);
    exp_ev(20'd200, 1'b0, 7);
    exp_ev(20'd0, 1'b1, 6);
    pulse_play();
    tick(5);
    pause_toggle = 1'b1;
    tick(1);
    pause_toggle = 1'b0;
    tick(10);
    #4;
    chk("pause_paused", 32'(paused), 1);
    chk("pause_playing", 32'(playing), 0);
    chk("pause_note_div", 32'(note_div), 0);
    tick(9);
    pause_toggle = 1'b1;
    tick(1);
    pause_toggle = 1'b0;
    tick(25);

    // live switch from song 1 to song 2
    exp_ev(20'd100, 1'b0, 3);
    exp_ev(20'd300, 1'b0, 3);
    exp_ev(20'd0, 1'b1, 6);
    pulse_play();
    tick(5);
    song_sel = 3'd2;
    tick(1);
    #4;
    chk("switch_rom_addr", 32'(rom_addr), 32'({3'd2, 6'd0}));
    chk("switch_playing", 32'(playing), 1);
    tick(15);

    // stop and play together: stop wins
    song_sel = 3'd1;
    tick(1);
    exp_ev(20'd100, 1'b0, 3);
    exp_ev(20'd0, 1'b0, 1);
    pulse_play();
    tick(4);
    stop = 1'b1;
    play = 1'b1;
    tick(1);
    stop = 1'b0;
    play = 1'b0;
    tick(1);
    #4;
    chk("stopplay_playing", 32'(playing), 0);
    chk("stopplay_note_div", 32'(note_div), 0);
    tick(3);

    // asynchronous reset in the middle of a note
    exp_ev(20'd100, 1'b0, 3);
    exp_ev(20'd0, 1'b0, 2);
    pulse_play();
    tick(4);
    rst = 1'b1;
    #1;
    chk("arst_note_div", 32'(note_div), 0);
    chk("arst_playing", 32'(playing), 0);
    chk("arst_rom_addr", 32'(rom_addr), 0);
    chk("arst_note_idx", 32'(note_idx), 0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // full-length song without end marker must stop at entry 63
    song_sel = 3'd3;
    tick(1);
    exp_ev(20'd1000, 1'b0, 3);
    for (int i = 1; i < 64; i++) exp_ev(20'(1000 + i), 1'b0, 6);
    exp_ev(20'd0, 1'b1, 4);
    pulse_play();
    tick(400);
    chk("full_note_idx", 32'(note_idx), 63);
    chk("full_rom_addr", 32'(rom_addr), 32'({3'd3, 6'd63}));
    chk("full_playing", 32'(playing), 0);
    tick(2);

    chk("sb_drain", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
